// File: rtl/kgp_alu_pkg.sv
// ------------------------------------------------------------------
// kgp_alu_pkg: ALU op codes, FSM encoding and helpers. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package kgp_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_COMP = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SHLL = 4'b0100;
  localparam logic [3:0] ALU_SHRL = 4'b0101;
  localparam logic [3:0] ALU_SHRA = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SHLL) || (code == ALU_SHRL) || (code == ALU_SHRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_multicycle_if.sv
// ------------------------------------------------------------------
// alu_multicycle_if: request/result bundle of the multicycle ALU. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_control_signal;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             sign;
  logic             illegal;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_control_signal, a, b,
    input  result, carry, zero, sign, illegal, busy, done
  );

  modport slave (
    input  start, alu_control_signal, a, b,
    output result, carry, zero, sign, illegal, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/alu_comb_unit.sv
// ------------------------------------------------------------------
// alu_comb_unit: single-cycle ADD/COMP/AND/XOR and illegal-code detect. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_comb_unit
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       code_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o,
  output logic             illegal_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    value_o   = '0;
    carry_o   = 1'b0;
    illegal_o = 1'b0;
    case (code_i)
      ALU_ADD:  {carry_o, value_o} = sum;
      ALU_COMP: value_o = (~b_i) + {{(WIDTH-1){1'b0}}, 1'b1};
      ALU_AND:  value_o = a_i & b_i;
      ALU_XOR:  value_o = a_i ^ b_i;
      // Shifts are legal but produced by the iterative datapath in the top.
      ALU_SHLL, ALU_SHRL, ALU_SHRA: ;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ------------------------------------------------------------------
// alu_multicycle: KGP-RISC execution unit with one-bit-per-cycle shifter. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_multicycle
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_multicycle_if.slave  bus
);

  alu_state_t         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   comb_value;
  logic               comb_carry;
  logic               comb_illegal;
  logic [WIDTH-1:0]   shifted;
  logic               shift_out;
  logic [SHAMT_W-1:0] shamt;
  logic               write_res;

  assign shamt = bus.b[SHAMT_W-1:0];

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .code_i    (bus.alu_control_signal),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .value_o   (comb_value),
    .carry_o   (comb_carry),
    .illegal_o (comb_illegal)
  );

  always_comb begin
    shifted   = acc_q;
    shift_out = 1'b0;
    case (op_q)
      ALU_SHLL: begin
        shifted   = {acc_q[WIDTH-2:0], 1'b0};
        shift_out = acc_q[WIDTH-1];
      end
      ALU_SHRL: begin
        shifted   = {1'b0, acc_q[WIDTH-1:1]};
        shift_out = acc_q[0];
      end
      ALU_SHRA: begin
        shifted   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        shift_out = acc_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    sign_d    = sign_q;
    illegal_d = illegal_q;
    write_res = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_shift(bus.alu_control_signal) && (shamt != '0)) begin
            acc_d   = bus.a;
            cnt_d   = shamt;
            op_d    = bus.alu_control_signal;
            state_d = ST_SHIFT;
          end else begin
            write_res = 1'b1;
            state_d   = ST_DONE;
            if (is_shift(bus.alu_control_signal)) begin
              result_d  = bus.a;
              carry_d   = 1'b0;
              illegal_d = 1'b0;
            end else begin
              result_d  = comb_value;
              carry_d   = comb_carry;
              illegal_d = comb_illegal;
            end
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - 1'b1;
        // Final step publishes the shifted value directly, saving a cycle.
        if (cnt_q == SHAMT_W'(1)) begin
          write_res = 1'b1;
          result_d  = shifted;
          carry_d   = shift_out;
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (write_res) begin
      zero_d = (result_d == '0);
      sign_d = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= ALU_ADD;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      sign_q    <= sign_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.result  = result_q;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;
  assign bus.sign    = sign_q;
  assign bus.illegal = illegal_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);

endmodule

`default_nettype wire
